// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default register-address width, NOP encoding and stall-counter width.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int REG_AW_DEF = 5;

    localparam logic [31:0] NOP_INSTR = 32'd0;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source/destination comparator for register data hazards, register 0 masked.
// With PIPE_FORWARDING_EN defined only an EXE-stage load can cause a stall.
module pipe_hazard_ctrl_hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              hazard
);

    logic exe_active;
    logic mem_active;
    logic unused_sig;

    function automatic logic reads(input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] s1,
                                   input logic [REG_AW-1:0] s2,
                                   input logic              two);
        return (dst != '0) && ((s1 == dst) || (two && (s2 == dst)));
    endfunction

`ifdef PIPE_FORWARDING_EN
    // Forwarding covers everything except a load result needed right away.
    assign exe_active = exe_wb_en && exe_mem_read;
    assign mem_active = 1'b0;
    assign unused_sig = ^{mem_dest, mem_wb_en};
`else
    assign exe_active = exe_wb_en;
    assign mem_active = mem_wb_en;
    assign unused_sig = exe_mem_read;
`endif

    assign hazard = (exe_active && reads(exe_dest, id_src1, id_src2, id_two_src)) ||
                    (mem_active && reads(mem_dest, id_src1, id_src2, id_two_src));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory waits > taken-branch flush > hazard stall.
// Optional PIPE_FORWARDING_EN narrows hazard detection to load-use only.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int REG_AW       = REG_AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      id_src1,
    input  logic [REG_AW-1:0]      id_src2,
    input  logic                   id_two_src,
    input  logic [REG_AW-1:0]      exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_read,
    input  logic [REG_AW-1:0]      mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_freeze,
    output logic                   if_id_freeze,
    output logic                   if_id_flush,
    output logic                   id_exe_bubble,
    output logic                   back_freeze,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [2:0] FLUSH_N   = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TIMEOUT_N = 8'(MEM_TIMEOUT);

    logic [1:0]             state_q,     state_d;
    logic [2:0]             flush_cnt_q, flush_cnt_d;
    logic [7:0]             wait_cnt_q,  wait_cnt_d;
    logic                   pending_q,   pending_d;
    logic                   mem_err_q,   mem_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic mem_wait;
    logic flush_now;
    logic stall_now;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    pipe_hazard_ctrl_hazard_cmp #(
        .REG_AW (REG_AW)
    ) u_hazard_cmp (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    always_comb begin
        mem_wait  = (mem_req && !mem_ready) || ((state_q == ST_WAIT) && !mem_ready);
        // The mem_ready cycle of WAIT neither flushes nor stalls.
        flush_now = !mem_wait &&
                    (((state_q == ST_RUN) && branch_taken) || (state_q == ST_FLUSH));
        stall_now = !mem_wait && (state_q == ST_RUN) && !branch_taken && hazard;
    end

    assign pc_freeze     = !rst && (mem_wait || stall_now);
    assign if_id_freeze  = !rst && (mem_wait || stall_now);
    assign back_freeze   = !rst && mem_wait;
    assign if_id_flush   = !rst && flush_now;
    assign id_exe_bubble = !rst && (flush_now || stall_now);
    assign mem_err       = mem_err_q;
    assign stall_count   = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = '0;
        pending_d   = pending_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_now ? sat_inc(stall_cnt_q) : stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d   = ST_WAIT;
                    pending_d = branch_taken;
                end else if (branch_taken && (FLUSH_N > 3'd1)) begin
                    // The branch cycle itself is the first flush cycle.
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 3'd1;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d     = (pending_q || branch_taken) ? ST_FLUSH : ST_RUN;
                    pending_d   = 1'b0;
                    flush_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
                    if (branch_taken) begin
                        pending_d = 1'b1;
                    end
                    if (wait_cnt_d == TIMEOUT_N) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (mem_wait) begin
                    // Interrupted flush is replayed in full once memory is ready.
                    state_d   = ST_WAIT;
                    pending_d = 1'b1;
                end else begin
                    flush_cnt_d = branch_taken ? 3'd1 : flush_cnt_q + 3'd1;
                    if (flush_cnt_d >= FLUSH_N) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            pending_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pending_q   <= pending_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the freeze/flush controls of the PC register and the IF/ID, ID/EXE and back-end (EXE/MEM, MEM/WB) pipe registers.
- Arbitrates between three sources: data-memory wait states, taken-branch flushes and register data hazards.
- Holds a small FSM for multi-cycle memory waits, branches that arrive during a wait, and flush extension.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID flush and ID/EXE bubble stay asserted per taken branch (1..7).
- MEM_TIMEOUT, 255, wait cycles after which mem_err is set (8-bit counter compare).
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  REG_AW  ID-stage source register 1.
- id_src2  in  REG_AW  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads id_src2.
- exe_dest  in  REG_AW  EXE-stage destination.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_dest  in  REG_AW  MEM-stage destination.
- mem_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  taken branch resolved in EXE.
- mem_req  in  1  MEM stage accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_freeze  out  1  hold PC.
- if_id_freeze  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID instruction.
- id_exe_bubble  out  1  load NOP into ID/EXE.
- back_freeze  out  1  hold EXE/MEM and MEM/WB.
- mem_err  out  1  sticky memory timeout flag.
- stall_count  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset: state RUN, flush counter 0, wait counter 0, pending_flush 0, mem_err 0, stall_count 0; all freeze/flush outputs 0 during reset.
- FSM states:
  - RUN → WAIT when mem_req && !mem_ready.
  - WAIT → RUN when mem_ready; if pending_flush is set, go to FLUSH instead.
  - RUN → FLUSH when branch_taken and FLUSH_CYCLES > 1.
  - FLUSH → RUN after FLUSH_CYCLES total flush cycles.
- Memory wait (highest priority):
  - Asserted combinationally in any cycle with mem_req && !mem_ready, and for the whole of WAIT while mem_ready is low.
  - Drives pc_freeze, if_id_freeze and back_freeze = 1, id_exe_bubble = 0, if_id_flush = 0.
  - The cycle mem_ready rises, all freezes drop in that same cycle.
- branch_taken during a wait: latched into pending_flush, with no flush during the wait. Flush cycles start the cycle after mem_ready.
- Taken-branch flush:
  - Asserts if_id_flush = 1 and id_exe_bubble = 1 in the cycle branch_taken is high (RUN).
  - Continues for FLUSH_CYCLES − 1 further cycles in FLUSH.
  - pc_freeze stays 0, so the redirected PC is loaded.
  - A flush overrides any hazard stall in the same cycle.
  - branch_taken arriving in FLUSH restarts the counter.
- Hazard stall (lowest priority), evaluated only in RUN with no branch:
  - Condition: id_src1 matches an active writer, or id_two_src && id_src2 matches an active writer.
  - Active writers: exe_dest with exe_wb_en; mem_dest with mem_wb_en.
  - Register 0 never matches.
  - Response: pc_freeze = 1, if_id_freeze = 1, id_exe_bubble = 1, back_freeze = 0.
  - stall_count increments by 1 per stall cycle and saturates at 0xFFFF.
- Wait counter:
  - Increments each WAIT cycle and clears on leaving WAIT.
  - When it reaches MEM_TIMEOUT, mem_err sets; it is cleared only by rst.
  - The pipeline still waits for mem_ready.
- Reset mid-wait or mid-flush returns immediately to RUN; pending_flush is dropped.
- if_id_freeze and if_id_flush are never both 1.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- When defined: the MEM-stage comparison is removed, and an EXE match stalls only when exe_mem_read = 1 (load-use, one cycle), because the forwarding unit covers all other cases.
- When undefined: full compare as described under Behaviour.

Decomposition:
- Shared pipeline package holds:
  - the FSM state encoding (RUN, WAIT, FLUSH);
  - the REG_AW default;
  - the NOP encoding constant 32'd0;
  - the stall-count width.
- One sub-module, hazard_cmp: combinational source/destination comparator with register-0 masking and the forwarding option; instantiated once.

Test Plan:
- Hazard stall: id_src1 = 3, exe_dest = 3, exe_wb_en = 1 → pc_freeze, if_id_freeze and id_exe_bubble are 1 for that cycle; stall_count 0 → 1. Repeat with id_src1 = 0 → no stall.
- Branch flush: FLUSH_CYCLES = 2, branch_taken pulse → if_id_flush = 1 and id_exe_bubble = 1 for exactly 2 cycles; pc_freeze = 0 throughout.
- Memory wait: mem_req = 1, mem_ready low for 4 cycles → pc_freeze, if_id_freeze and back_freeze high for 4 cycles, drop on the mem_ready cycle. A branch_taken during the wait → flush starts the cycle after mem_ready.
- Timeout: MEM_TIMEOUT = 8, mem_ready held low for 10 cycles → mem_err rises after the 8th WAIT cycle and stays 1 until rst.
- Priority and reset: branch_taken and a hazard in the same cycle → flush only, stall_count unchanged. rst mid-WAIT → all outputs 0 the next cycle.
- PIPE_FORWARDING_EN: mem_dest = 5 match → no stall; exe_dest = 5 with exe_mem_read = 1 → 1-cycle stall.
